// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       branchLEG;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       illegal_op;
  logic       instr_done;

  modport master (
    input  op, func3, func7, zero, branchLEG, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op, instr_done
  );

  modport slave (
    output op, func3, func7, zero, branchLEG, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op, instr_done
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle RV32 subset datapath.
// Define MEM_WAIT_STATE_EN to make FETCH/MEMREAD/MEMWRITE wait for mem_ready.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXER     = 4'd2;
  localparam logic [3:0] S_EXEI     = 4'd3;
  localparam logic [3:0] S_ALUWB    = 4'd4;
  localparam logic [3:0] S_MEMADR   = 4'd5;
  localparam logic [3:0] S_MEMREAD  = 4'd6;
  localparam logic [3:0] S_MEMWB    = 4'd7;
  localparam logic [3:0] S_MEMWRITE = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR1    = 4'd11;
  localparam logic [3:0] S_JALR2    = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic ready;
`ifdef MEM_WAIT_STATE_EN
  assign ready = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign ready = 1'b1;
`endif

  logic [3:0] state;
  logic [3:0] next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (ready) next_state = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_R:         next_state = S_EXER;
          OP_I:         next_state = S_EXEI;
          OP_LD, OP_ST: next_state = S_MEMADR;
          OP_BR:        next_state = S_BRANCH;
          OP_JAL:       next_state = S_JAL;
          OP_JALR:      next_state = S_JALR1;
          OP_LUI:       next_state = S_LUI;
          default:      next_state = S_FETCH;
        endcase
      end
      S_EXER, S_EXEI:   next_state = S_ALUWB;
      S_MEMADR:         next_state = (bus.op == OP_ST) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:        if (ready) next_state = S_MEMWB;
      S_MEMWRITE:       if (ready) next_state = S_FETCH;
      S_JAL, S_JALR2:   next_state = S_ALUWB;
      S_JALR1:          next_state = S_JALR2;
      S_ALUWB, S_MEMWB, S_BRANCH, S_LUI: next_state = S_FETCH;
      default:          next_state = S_FETCH;
    endcase
  end

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, done;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    done        = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    case (state)
      S_FETCH: begin
        ir_write   = ready;
        pc_write   = ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        // Precompute the branch/jump target OldPC+imm into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (bus.op == OP_BR) ? IMM_B : (bus.op == OP_JAL) ? IMM_J : IMM_I;
        case (bus.op)
          OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_EXER: begin
        alu_src_a = 2'b10;
        case ({bus.func7, bus.func3})
          10'b0100000_000: alu_control = ALU_SUB;
          10'b0000000_111: alu_control = ALU_AND;
          10'b0000000_110: alu_control = ALU_OR;
          10'b0000000_010: alu_control = ALU_SLT;
          default:         alu_control = ALU_ADD;
        endcase
      end
      S_EXEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        case (bus.func3)
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b010:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (bus.op == OP_ST) ? IMM_S : IMM_I;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        done      = ready;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        done      = 1'b1;
        case (bus.func3)
          3'b000: begin alu_control = ALU_SUB; pc_write = bus.zero;       end
          3'b001: begin alu_control = ALU_SUB; pc_write = !bus.zero;      end
          3'b100: begin alu_control = ALU_SLT; pc_write = bus.branchLEG;  end
          3'b101: begin alu_control = ALU_SLT; pc_write = !bus.branchLEG; end
          default: ;
        endcase
      end
      S_JAL, S_JALR2: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_JALR1: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = 2'b11;
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by rst_n so nothing fires while reset is held.
  assign bus.PCWrite    = pc_write  & rst_n;
  assign bus.IRWrite    = ir_write  & rst_n;
  assign bus.MemWrite   = mem_write & rst_n;
  assign bus.RegWrite   = reg_write & rst_n;
  assign bus.illegal_op = illegal   & rst_n;
  assign bus.instr_done = done      & rst_n;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op  in  7  opcode from IR.
REQ-005 func3  in  3  IR[14:12].
REQ-006 func7  in  7  IR[31:25].
REQ-007 zero  in  1  ALU result == 0.
REQ-008 branchLEG  in  1  ALU signed-less-than flag.
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 PCWrite  out  1  PC load strobe.
REQ-011 AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
REQ-012 MemWrite  out  1  memory write strobe.
REQ-013 IRWrite  out  1  loads IR and OldPC.
REQ-014 RegWrite  out  1  register file write strobe.
REQ-015 ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
REQ-016 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
REQ-017 ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4.
REQ-018 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-019 ImmSrc  out  3  000 I, 001 S, 010 J, 011 B, 100 U.
REQ-020 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-021 instr_done  out  1  one-cycle pulse in the last state of every instruction.

Function
REQ-022 The block SHALL be a Moore FSM; outputs SHALL be combinational from state, except the PCWrite branch term and the mem_ready gating.
REQ-023 Outputs not listed for a state SHALL be 0.
REQ-024 FETCH SHALL drive: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10, PCWrite 1; next state DECODE.
REQ-025 DECODE SHALL drive: ALUSrcA 01, ALUSrcB 01, add, with ImmSrc taken from op (B for 1100011, J for 1101111, otherwise I), so that ALUOut = OldPC+imm.
REQ-026 DECODE SHALL branch on op as follows:
- 0110011 -> EXER
- 0010011 -> EXEI
- 0000011 or 0100011 -> MEMADR
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR1
- 0110111 -> LUI
- any other op -> FETCH, with illegal_op pulsed for that one DECODE cycle.
REQ-027 EXER (A=10, B=00) SHALL decode {func7,func3}: add 000, sub 001, and 010, or 011, slt 101; any other combination -> add. EXEI (A=10, B=01, ImmSrc I) SHALL decode func3: 000 add, 100 xor, 110 or, 010 slt, else add. Both states SHALL go to ALUWB.
REQ-028 ALUWB SHALL drive ResultSrc 00 and RegWrite 1, then go to FETCH.
REQ-029 MEMADR SHALL drive A=10, B=01, add, ImmSrc I for loads or S for stores, then go to MEMREAD for loads or MEMWRITE for stores. MEMREAD (AdrSrc 1) SHALL go to MEMWB. MEMWB SHALL drive ResultSrc 01 and RegWrite 1, then go to FETCH. MEMWRITE SHALL drive AdrSrc 1 and MemWrite 1, then go to FETCH.
REQ-030 BRANCH SHALL drive A=10, B=00, ResultSrc 00. beq/bne SHALL use sub; blt/bge SHALL use slt. PCWrite SHALL equal: zero for beq, !zero for bne, branchLEG for blt, !branchLEG for bge, and 0 for any other func3. Next state FETCH.
REQ-031 JAL SHALL drive A=01, B=10, add, ResultSrc 00, PCWrite 1, then go to ALUWB.
REQ-032 JALR1 SHALL drive A=10, B=01, ImmSrc I, add, then go to JALR2. JALR2 SHALL drive A=01, B=10, add, ResultSrc 00, PCWrite 1, then go to ALUWB.
REQ-033 LUI SHALL drive ImmSrc 100, ResultSrc 11, RegWrite 1, then go to FETCH.
REQ-034 instr_done SHALL be asserted in ALUWB, MEMWB, MEMWRITE, BRANCH and LUI, gated by mem_ready where REQ-040 applies.
REQ-035 Instruction latency SHALL be: R/I/JAL/LUI... as follows — R, I and JAL 4 cycles; LUI and branch 3; load 5; store 4; JALR 5.

Reset
REQ-036 When rst_n is low, the state SHALL become FETCH immediately (asynchronously).
REQ-037 While rst_n is low, PCWrite, IRWrite, MemWrite, RegWrite, illegal_op and instr_done SHALL be forced to 0.
REQ-038 A reset asserted mid-instruction SHALL abort the instruction with no further strobes; the first cycle after release SHALL be FETCH.

Configuration
REQ-039 The macro MEM_WAIT_STATE_EN SHALL select wait-state support.
REQ-040 With MEM_WAIT_STATE_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold while mem_ready = 0. IRWrite, PCWrite and instr_done SHALL assert only in the cycle where mem_ready = 1. MemWrite SHALL stay high throughout the hold.
REQ-041 With MEM_WAIT_STATE_EN undefined, mem_ready SHALL be ignored and every memory access SHALL take one cycle.

Verification
REQ-042 add x3,x1,x2 (op 0110011, f7 0, f3 0): states FETCH, DECODE, EXER, ALUWB; ALUControl 000 in EXER; RegWrite 1 only in cycle 4.
REQ-043 beq with zero = 1: PCWrite 1 in cycle 3, then FETCH. bge with branchLEG = 1: PCWrite 0 in cycle 3.
REQ-044 sw (op 0100011): ImmSrc 001 in MEMADR, MemWrite 1 for exactly one cycle (cycle 4), RegWrite never asserted.
REQ-045 op = 7'h7F: illegal_op 1 in cycle 2, FETCH in cycle 3, no RegWrite or MemWrite.
REQ-046 MEM_WAIT_STATE_EN defined, lw with mem_ready low for 2 cycles in FETCH and 2 cycles in MEMREAD: total latency 9 cycles, IRWrite high in cycle 3 only.
REQ-047 rst_n pulled low during MEMWRITE: MemWrite drops to 0 in the same cycle; FETCH follows release.
